// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin index arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ         = 8;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned DEFAULT_TIMEOUT = 15;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req bit starting just after ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest (ptr itself) to nearest (ptr+1) so the nearest hit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_index_arbiter.sv
// 8-requester round-robin arbiter emitting the winner as index bits a/b/c.
// Optional forced release after TIMEOUT grant cycles when ARB_TIMEOUT_EN is defined.
module rr_index_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned TO_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               valid,
  output logic               timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             rel;
  logic             force_rel;
  logic             timeout_q;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // done and a dropped request together are still one release.
  assign rel = (state_q == GRANT) && (done || !req[idx_q]);

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_d;

  assign force_rel = (state_q == GRANT) && !rel && (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d     = (state_q == GRANT) ? cnt_q + 1'b1 : '0;
    timeout_d = force_rel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, TO_W};
  assign force_rel  = 1'b0;
  assign timeout_q  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          idx_d   = pick_idx;
        end
      end
      GRANT: begin
        if (rel || force_rel) begin
          state_d = IDLE;
          ptr_d   = idx_q;
        end
      end
    endcase
  end

  always_comb begin
    {a, b, c} = idx_q;
    valid     = (state_q == GRANT);
    timeout   = timeout_q;
  end

endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- 8-requester round-robin arbiter; outputs the 3-bit winning index as separate bits a, b, c (a = MSB).
- Sits directly upstream of the team's 3-to-8 line decoder, which expands a/b/c into the one-hot grant lines y0..y7.
- Grant is held until the owner signals done or withdraws its request.
- valid qualifies the index; the decoder outputs are meaningful only while valid=1.

Parameters:
- TIMEOUT, 15, max cycles a grant may be held before forced release (used only with ARB_TIMEOUT_EN).
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i] = requester i wants the resource.
- done  input  1  one-cycle pulse from current owner: transfer complete.
- a  output  1  grant index bit 2 (MSB), registered.
- b  output  1  grant index bit 1, registered.
- c  output  1  grant index bit 0 (LSB), registered.
- valid  output  1  index a/b/c is a live grant, registered.
- timeout  output  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (async, rst=1): state=IDLE, a=b=c=0, valid=0, timeout=0, last pointer ptr=7 (first search starts at index 0), counter=0.
- States: IDLE, GRANT.
- IDLE: if req != 0, pick the first set req bit searching (ptr+1) mod 8 upward with wrap.
  - At the next edge: {a,b,c} = picked index, valid=1, go to GRANT.
  - Latency: req seen at edge N -> valid=1 after edge N+1.
  - If req == 0: stay in IDLE, valid=0, a/b/c hold their last value.
- GRANT: owner = {a,b,c}.
  - Release when done=1 or req[owner]=0. Simultaneous done and drop count as a single release.
  - On release, at the edge: ptr=owner, valid=0, state=IDLE.
  - One mandatory idle cycle between grants: back-to-back grants are spaced 2 cycles.
- Requests from non-owners during GRANT are ignored and do not preempt.
- done while in IDLE is ignored.
- Fairness: requester i, once requesting continuously, is granted within 7 intervening grants.
- Wrap: ptr=7 searches from 0; ptr=6 with only req[6] set re-grants 6 after the full wrap.
- a/b/c change only on the edge that enters GRANT; they are stable for the whole grant.
- Asserting rst mid-grant drops valid immediately (async) and restores ptr=7.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches TIMEOUT with no release, force release at that edge: ptr=owner, valid=0, timeout=1 for one cycle, state=IDLE.
  - A normal release in the same cycle takes precedence: timeout stays 0.
- Undefined: no counter; timeout is constant 0; a grant can be held indefinitely.

Decomposition:
- Package arb_pkg:
  - NUM_REQ=8, IDX_W=3.
  - State typedef {IDLE, GRANT}.
  - Default TIMEOUT constant.
- Sub-module rr_pick (combinational):
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], any.
  - Function: rotating-priority search, instantiated once.
- FSM, registers and the timeout counter stay in the top module.

Test Plan:
- Reset then req=8'b0000_0001 -> valid=1 after next edge, {a,b,c}=000; pulse done -> valid=0 next edge, ptr=0.
- req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0; valid low exactly one cycle between grants.
- Grant index 5, req[5] dropped with done=0 -> valid=0 next edge; next pick searches from 6 (req=8'b0010_0001 -> index 0 after wrap).
- Grant index 3, done and req[3] drop in the same cycle -> single release, no double pointer advance; next grant of req[4] gives {a,b,c}=100.
- ARB_TIMEOUT_EN, TIMEOUT=15, owner never sends done -> release at the 15th GRANT cycle, timeout pulses one cycle, next requester granted; without the macro, valid stays 1 for more than 100 cycles.
- rst asserted mid-GRANT between edges -> valid=0, a/b/c=000 immediately; after release, req=8'h80 -> index 7 is granted ({a,b,c}=111).
